// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-line instruction cache.
// The datapath fetch port gets hits back in the same cycle. A miss stalls the
// fetch (ihit=0) while a single word is read from the memory controller. The
// filled word is returned by the lookup on the cycle after the fill.
module icache_responder #(
    parameter int SETS  = 16,
    parameter int IDX_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             imemREN,
    input  logic [31:0]      imemaddr,
    output logic             ihit,
    output logic [31:0]      imemload,
    output logic             iREN,
    output logic [31:0]      iaddr,
    input  logic             iwait,
    input  logic [31:0]      iload,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    localparam int TAG_W = 32 - IDX_W - 2;

    typedef enum logic {IDLE, FILL} state_t;

    // Control state: reset clears these
    state_t            state_q, state_d;
    logic [SETS-1:0]   valid_q, valid_d;
    logic [31:0]       miss_addr_q, miss_addr_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    // Line storage: only meaningful where the valid bit is set, so never reset
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [31:0]       data_q [SETS];

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              hit;
    logic              fill_we;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (&v) ? v : v + one;
    endfunction

    assign lk_idx   = imemaddr[IDX_W+1:2];
    assign lk_tag   = imemaddr[31:IDX_W+2];
    assign fill_idx = miss_addr_q[IDX_W+1:2];
    assign fill_tag = miss_addr_q[31:IDX_W+2];

    // Lookups only happen in IDLE; a pending fill blocks all hits.
    assign hit = (state_q == IDLE) && imemREN && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign ihit     = hit;
    assign imemload = hit ? data_q[lk_idx] : 32'd0;
    assign iREN     = (state_q == FILL);
    assign iaddr    = (state_q == FILL) ? miss_addr_q : 32'd0;
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

    // Next-state: hit counting, miss capture, and fill completion
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        miss_addr_d = miss_addr_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        fill_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    hit_cnt_d = sat_inc(hit_cnt_q);
                end else if (imemREN) begin
                    miss_addr_d = {imemaddr[31:2], 2'b00};
                    miss_cnt_d  = sat_inc(miss_cnt_q);
                    state_d     = FILL;
                end
            end
            FILL: begin
                // Fill is committed regardless of what the datapath does meanwhile
                if (!iwait) begin
                    fill_we           = 1'b1;
                    valid_d[fill_idx] = 1'b1;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers with asynchronous reset; a reset mid-fill drops the fill
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            miss_addr_q <= 32'd0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            miss_addr_q <= miss_addr_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Line write on fill completion (eviction is a plain overwrite)
    always_ff @(posedge CLK) begin
        if (fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: directed scenarios plus randomized traffic
// checked against a behavioural cache model. Counters are narrowed to 8 bits
// so saturation is reachable.
module tb_icache_responder;
    localparam int SETS  = 16;
    localparam int IDX_W = 4;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             imemREN;
    logic [31:0]      imemaddr;
    logic             ihit;
    logic [31:0]      imemload;
    logic             iREN;
    logic [31:0]      iaddr;
    logic             iwait;
    logic [31:0]      iload;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    icache_responder #(.SETS(SETS), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: each set remembers which word address it holds
    bit          m_valid [SETS];
    logic [29:0] m_word  [SETS];
    logic [31:0] m_data  [SETS];
    bit          m_fill;
    logic [31:0] m_miss;
    int          m_hits;
    int          m_misses;

    function automatic int set_of(input logic [31:0] a);
        return int'(a[IDX_W+1:2]);
    endfunction

    function automatic bit m_hit();
        int s;
        s = set_of(imemaddr);
        return !m_fill && imemREN && m_valid[s] && (m_word[s] == imemaddr[31:2]);
    endfunction

    function automatic logic [31:0] m_load();
        return m_hit() ? m_data[set_of(imemaddr)] : 32'd0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
        m_fill   = 1'b0;
        m_miss   = 32'd0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    // Advance one clock, updating the model with the inputs seen at the edge
    task automatic tick();
        bit h;
        h = m_hit();
        @(posedge CLK);
        if (!m_fill) begin
            if (h) begin
                if (m_hits < CMAX) m_hits++;
            end else if (imemREN) begin
                m_miss = {imemaddr[31:2], 2'b00};
                if (m_misses < CMAX) m_misses++;
                m_fill = 1'b1;
            end
        end else if (!iwait) begin
            m_valid[set_of(m_miss)] = 1'b1;
            m_word[set_of(m_miss)]  = m_miss[31:2];
            m_data[set_of(m_miss)]  = iload;
            m_fill = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b1;
        m_reset();
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b0;
    endtask

    task automatic test_reset();
        imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b1; iload = 32'hDEAD_BEEF;
        nRST = 1'b1;
        m_reset();
        #3;
        @(negedge CLK);
        n_assert++;
        if (ihit !== 1'b0 || imemload !== 32'd0) begin
            n_fail++; $display("FAIL reset_hit: ihit=%b imemload=%h expected 0/0", ihit, imemload);
        end
        n_assert++;
        if (iREN !== 1'b0 || iaddr !== 32'd0) begin
            n_fail++; $display("FAIL reset_mem: iREN=%b iaddr=%h expected 0/0", iREN, iaddr);
        end
        n_assert++;
        if (hit_cnt !== '0 || miss_cnt !== '0) begin
            n_fail++; $display("FAIL reset_cnt: hit=%0d miss=%0d expected 0/0", hit_cnt, miss_cnt);
        end
        @(posedge CLK); #1;
        nRST = 1'b0;
    endtask

    task automatic test_miss_fill();
        imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b0; iload = 32'h2001_0005;
        @(negedge CLK);
        n_assert++;
        if (ihit !== 1'b0 || iREN !== 1'b0) begin
            n_fail++; $display("FAIL miss_first: ihit=%b iREN=%b expected 0/0", ihit, iREN);
        end
        tick();
        @(negedge CLK);
        n_assert++;
        if (iREN !== 1'b1 || iaddr !== 32'h40 || ihit !== 1'b0) begin
            n_fail++; $display("FAIL fill_req: iREN=%b iaddr=%h ihit=%b expected 1/00000040/0", iREN, iaddr, ihit);
        end
        tick();
        @(negedge CLK);
        n_assert++;
        if (ihit !== 1'b1 || imemload !== 32'h2001_0005 || miss_cnt !== 8'd1) begin
            n_fail++; $display("FAIL after_fill: ihit=%b load=%h miss=%0d expected 1/20010005/1", ihit, imemload, miss_cnt);
        end
        tick();
    endtask

    task automatic test_hit_offset();
        logic [31:0] addrs [4];
        addrs[0] = 32'h40; addrs[1] = 32'h43; addrs[2] = 32'h41; addrs[3] = 32'h40;
        for (int i = 0; i < 4; i++) begin
            imemaddr = addrs[i];
            @(negedge CLK);
            n_assert++;
            if (ihit !== 1'b1 || imemload !== 32'h2001_0005) begin
                n_fail++; $display("FAIL hit_offset[%0d]: ihit=%b load=%h expected 1/20010005", i, ihit, imemload);
            end
            n_assert++;
            if (hit_cnt !== CNT_W'(i + 1)) begin
                n_fail++; $display("FAIL hit_count[%0d]: hit_cnt=%0d expected %0d", i, hit_cnt, i + 1);
            end
            tick();
        end
    endtask

    task automatic test_conflict();
        iwait = 1'b0;
        imemaddr = 32'h80; iload = 32'h1111_2222;
        tick(); tick();
        @(negedge CLK);
        n_assert++;
        if (ihit !== 1'b1 || imemload !== 32'h1111_2222) begin
            n_fail++; $display("FAIL conflict_80: ihit=%b load=%h expected 1/11112222", ihit, imemload);
        end
        tick();
        imemaddr = 32'h40; iload = 32'h2001_0005;
        @(negedge CLK);
        n_assert++;
        if (ihit !== 1'b0) begin
            n_fail++; $display("FAIL conflict_evict: ihit=%b expected 0", ihit);
        end
        tick();
        @(negedge CLK);
        n_assert++;
        if (iREN !== 1'b1 || iaddr !== 32'h40 || miss_cnt !== 8'd3) begin
            n_fail++; $display("FAIL conflict_refill: iREN=%b iaddr=%h miss=%0d expected 1/00000040/3", iREN, iaddr, miss_cnt);
        end
        tick();
    endtask

    task automatic test_wait_stall();
        iwait = 1'b0; imemaddr = 32'h80; iload = 32'h3333_4444;
        tick(); tick();
        imemaddr = 32'h40; iwait = 1'b1; iload = 32'h5555_6666;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) imemaddr = 32'h100;
            @(negedge CLK);
            n_assert++;
            if (iREN !== 1'b1 || iaddr !== 32'h40 || ihit !== 1'b0) begin
                n_fail++; $display("FAIL stall[%0d]: iREN=%b iaddr=%h ihit=%b expected 1/00000040/0", i, iREN, iaddr, ihit);
            end
            tick();
        end
        iwait = 1'b0;
        @(negedge CLK);
        n_assert++;
        if (iREN !== 1'b1 || iaddr !== 32'h40 || ihit !== 1'b0) begin
            n_fail++; $display("FAIL stall_done: iREN=%b iaddr=%h ihit=%b expected 1/00000040/0", iREN, iaddr, ihit);
        end
        tick();
        n_assert++;
        if (!(m_valid[0] && m_word[0] == 30'h10 && m_data[0] == 32'h5555_6666)) begin
            n_fail++; $display("FAIL stall_model: set0 word=%h data=%h expected 00000010/55556666", m_word[0], m_data[0]);
        end
        @(negedge CLK);
        n_assert++;
        if (ihit !== 1'b0) begin
            n_fail++; $display("FAIL new_addr_miss: ihit=%b expected 0", ihit);
        end
        tick();
        @(negedge CLK);
        n_assert++;
        if (iREN !== 1'b1 || iaddr !== 32'h100) begin
            n_fail++; $display("FAIL new_addr_fill: iREN=%b iaddr=%h expected 1/00000100", iREN, iaddr);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid_fill();
        iwait = 1'b1; imemaddr = 32'h3C4; imemREN = 1'b1; iload = 32'hCAFE_F00D;
        tick();
        n_assert++;
        if (iREN !== 1'b1) begin
            n_fail++; $display("FAIL rst_fill_pre: iREN=%b expected 1", iREN);
        end
        iwait = 1'b0;
        nRST = 1'b1;
        m_reset();
        #1;
        n_assert++;
        if (iREN !== 1'b0 || iaddr !== 32'd0 || miss_cnt !== '0) begin
            n_fail++; $display("FAIL rst_fill_drop: iREN=%b iaddr=%h miss=%0d expected 0/0/0", iREN, iaddr, miss_cnt);
        end
        @(posedge CLK); #1;
        nRST = 1'b0;
        imemaddr = 32'h40;
        @(negedge CLK);
        n_assert++;
        if (ihit !== 1'b0) begin
            n_fail++; $display("FAIL rst_valid_clr: ihit=%b expected 0", ihit);
        end
        iwait = 1'b0; iload = 32'h7777_8888;
        tick(); tick();
        imemaddr = 32'h3C4;
        @(negedge CLK);
        n_assert++;
        if (ihit !== 1'b0) begin
            n_fail++; $display("FAIL rst_old_miss: ihit=%b expected 0", ihit);
        end
        tick();
        @(negedge CLK);
        n_assert++;
        if (iREN !== 1'b1 || iaddr !== 32'h3C4) begin
            n_fail++; $display("FAIL rst_old_refill: iREN=%b iaddr=%h expected 1/000003c4", iREN, iaddr);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            imemREN  = ($urandom_range(0, 3) != 0);
            imemaddr = {22'($urandom_range(0, 2)), 4'($urandom_range(0, 5)), 4'($urandom), 2'($urandom)};
            iwait    = ($urandom_range(0, 1) == 1);
            iload    = $urandom;
            @(negedge CLK);
            n_assert++;
            if (ihit !== m_hit() || imemload !== m_load()) begin
                n_fail++; $display("FAIL rand_hit[%0d]: ihit=%b load=%h expected %b/%h", c, ihit, imemload, m_hit(), m_load());
            end
            n_assert++;
            if (iREN !== m_fill || iaddr !== (m_fill ? m_miss : 32'd0)) begin
                n_fail++; $display("FAIL rand_mem[%0d]: iREN=%b iaddr=%h expected %b/%h", c, iREN, iaddr, m_fill, m_fill ? m_miss : 32'd0);
            end
            n_assert++;
            if (hit_cnt !== CNT_W'(m_hits) || miss_cnt !== CNT_W'(m_misses)) begin
                n_fail++; $display("FAIL rand_cnt[%0d]: hit=%0d miss=%0d expected %0d/%0d", c, hit_cnt, miss_cnt, m_hits, m_misses);
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        do_reset();
        imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b0; iload = 32'hABCD_0123;
        tick(); tick();
        repeat (CMAX + 5) tick();
        @(negedge CLK);
        n_assert++;
        if (hit_cnt !== 8'hFF || ihit !== 1'b1) begin
            n_fail++; $display("FAIL sat_reach: hit_cnt=%h ihit=%b expected ff/1", hit_cnt, ihit);
        end
        tick();
        @(negedge CLK);
        n_assert++;
        if (hit_cnt !== 8'hFF || miss_cnt !== 8'd1) begin
            n_fail++; $display("FAIL sat_hold: hit_cnt=%h miss=%0d expected ff/1", hit_cnt, miss_cnt);
        end
    endtask

    initial begin
        nRST = 1'b1; imemREN = 1'b0; imemaddr = 32'd0; iwait = 1'b1; iload = 32'd0;
        test_reset();
        test_miss_fill();
        test_hit_offset();
        test_conflict();
        test_wait_stall();
        test_reset_mid_fill();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
